// File: rtl/avg_accum_n.sv
// Coherent averager: sums 2^n lines in an RMW accumulator RAM, then streams the scaled average.
// First word <= 3 clk after line end; out_valid/out_data hold under out_ready backpressure via a 1-entry skid.
module avg_accum_n #(
  parameter int DW        = 10,
  parameter int AW        = 13,
  parameter int LEN       = 8192,
  parameter int MAX_LOG2N = 6,
  parameter int ACCW      = DW + MAX_LOG2N,
  parameter int ROUND     = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [2:0]    cfg_log2n,
  input  logic          line_valid,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          len_err
);

  localparam logic [AW:0]          LEN_A   = LEN[AW:0];
  localparam logic [MAX_LOG2N:0]   ONE_C   = {{MAX_LOG2N{1'b0}}, 1'b1};
  localparam logic [ACCW:0]        ONE_R   = {{ACCW{1'b0}}, 1'b1};
  localparam logic [ACCW:0]        MAX_OUT = {{(ACCW+1-DW){1'b0}}, {DW{1'b1}}};
  localparam logic [2:0]           MAX_N   = MAX_LOG2N[2:0];

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_ACC, S_DRAIN, S_DONE} state_t;

  state_t                 state;
  logic [2:0]             n_log;
  logic [MAX_LOG2N-1:0]   line_cnt;
  logic [AW:0]            addr;
  logic                   lv_q;

  logic [ACCW-1:0]        mem [0:(1<<AW)-1];
  logic [ACCW-1:0]        rd_q;
  logic                   wr_en_q;
  logic                   wr_first_q;
  logic [AW-1:0]          wr_addr_q;
  logic [DW-1:0]          wr_din_q;

  logic                   rd_pend;
  logic                   rd_pend_last;
  logic                   skid_vld;
  logic                   skid_last;
  logic [DW-1:0]          skid_dat;

  logic                   rise;
  logic                   samp;
  logic                   samp_ok;
  logic                   last_line;
  logic                   xfer;
  logic                   issue;
  logic                   rd_en;
  logic [ACCW:0]          rnd;
  logic [ACCW:0]          rnd_sum;
  logic [ACCW:0]          shifted;
  logic [DW-1:0]          land_dat;
  logic                   ov_n, ol_n, sv_n, sl_n;
  logic [DW-1:0]          od_n, sd_n;

  // A sample on the very cycle line_valid rises still belongs to the new line.
  assign rise      = line_valid && !lv_q;
  assign samp      = din_valid && line_valid &&
                     ((state == S_ACC) || ((state == S_ARM) && rise));
  assign samp_ok   = samp && (addr < LEN_A);
  assign last_line = ({1'b0, line_cnt} == ((ONE_C << n_log) - ONE_C));
  assign xfer      = out_valid && out_ready;
  assign rd_en     = samp_ok || issue;

  always_comb begin
    rnd = '0;
    if (ROUND != 0 && n_log != 3'd0) rnd = ONE_R << (n_log - 3'd1);
    rnd_sum  = {1'b0, rd_q} + rnd;
    shifted  = rnd_sum >> n_log;
    land_dat = (shifted > MAX_OUT) ? {DW{1'b1}} : shifted[DW-1:0];
  end

  // Output register plus skid; a read is issued only if its landing slot is guaranteed.
  always_comb begin
    ov_n = out_valid;
    od_n = out_data;
    ol_n = out_last;
    sv_n = skid_vld;
    sd_n = skid_dat;
    sl_n = skid_last;
    if (!out_valid || xfer) begin
      if (skid_vld) begin
        ov_n = 1'b1;
        od_n = skid_dat;
        ol_n = skid_last;
        sv_n = rd_pend;
        sd_n = land_dat;
        sl_n = rd_pend_last;
      end else begin
        ov_n = rd_pend;
        od_n = rd_pend ? land_dat : out_data;
        ol_n = rd_pend && rd_pend_last;
      end
    end else if (rd_pend) begin
      sv_n = 1'b1;
      sd_n = land_dat;
      sl_n = rd_pend_last;
    end
    issue = (state == S_DRAIN) && (addr < LEN_A) && !(ov_n && sv_n);
  end

  always_ff @(posedge clk) begin
    if (wr_en_q)
      mem[wr_addr_q] <= (wr_first_q ? '0 : rd_q) + {{(ACCW-DW){1'b0}}, wr_din_q};
    if (rd_en)
      rd_q <= mem[addr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      n_log        <= '0;
      line_cnt     <= '0;
      addr         <= '0;
      lv_q         <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_first_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_din_q     <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      skid_vld     <= 1'b0;
      skid_last    <= 1'b0;
      skid_dat     <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      lv_q       <= line_valid;
      done       <= 1'b0;
      wr_en_q    <= samp_ok && !abort;
      wr_first_q <= (line_cnt == '0);
      wr_addr_q  <= addr[AW-1:0];
      wr_din_q   <= din;
      if (abort) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        skid_vld  <= 1'b0;
        skid_last <= 1'b0;
        rd_pend   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            n_log    <= (cfg_log2n > MAX_N) ? MAX_N : cfg_log2n;
            len_err  <= 1'b0;
            line_cnt <= '0;
            addr     <= '0;
            busy     <= 1'b1;
            state    <= S_ARM;
          end
          S_ARM, S_ACC: begin
            if (samp) begin
              if (samp_ok) addr <= addr + 1'b1;
              else         len_err <= 1'b1;
            end
            if (state == S_ARM) begin
              if (rise) state <= S_ACC;
            end else if (!line_valid) begin
              if (addr != LEN_A) len_err <= 1'b1;
              addr <= '0;
              if (last_line) begin
                state <= S_DRAIN;
              end else begin
                line_cnt <= line_cnt + 1'b1;
                state    <= S_ARM;
              end
            end
          end
          S_DRAIN: begin
            out_valid <= ov_n;
            out_data  <= od_n;
            out_last  <= ol_n;
            skid_vld  <= sv_n;
            skid_dat  <= sd_n;
            skid_last <= sl_n;
            rd_pend   <= issue;
            if (issue) begin
              rd_pend_last <= (addr == LEN_A - 1'b1);
              addr         <= addr + 1'b1;
            end
            if (xfer && out_last) begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avg_accum_n.sv
// Directed bench: rounded and truncating averagers (LEN=16) driven in lockstep.
module tb_avg_accum_n;
  logic       clk = 1'b0;
  logic       reset_n, start, abort, line_valid, din_valid, out_ready;
  logic [2:0] cfg_log2n;
  logic [9:0] din;
  logic       r_valid, r_last, r_busy, r_done, r_err;
  logic       t_valid, t_last, t_busy, t_done, t_err;
  logic [9:0] r_data, t_data;

  int n_checks = 0;
  int n_errors = 0;
  int exp_r[16];
  int exp_t[16];

  always #5 clk = ~clk;

  avg_accum_n #(.DW(10), .AW(4), .LEN(16), .MAX_LOG2N(6), .ROUND(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .cfg_log2n(cfg_log2n),
    .line_valid(line_valid), .din_valid(din_valid), .din(din),
    .out_valid(r_valid), .out_ready(out_ready), .out_data(r_data), .out_last(r_last),
    .busy(r_busy), .done(r_done), .len_err(r_err));

  avg_accum_n #(.DW(10), .AW(4), .LEN(16), .MAX_LOG2N(6), .ROUND(0)) u_dut_tr (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .cfg_log2n(cfg_log2n),
    .line_valid(line_valid), .din_valid(din_valid), .din(din),
    .out_valid(t_valid), .out_ready(out_ready), .out_data(t_data), .out_last(t_last),
    .busy(t_busy), .done(t_done), .len_err(t_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_start(input int log2n, input string nm);
    @(negedge clk);
    cfg_log2n = log2n[2:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s_busy", nm), r_busy, 1);
    chk($sformatf("%s_err_clr", nm), r_err, 0);
  endtask

  // kind 0: i+ln, 1: 1023, 2: 3*i, 3: i+5
  task automatic send_line(input int nsamp, input int kind, input int ln);
    int v;
    for (int i = 0; i < nsamp; i++) begin
      @(negedge clk);
      case (kind)
        0:       v = i + ln;
        1:       v = 1023;
        2:       v = 3 * i;
        default: v = i + 5;
      endcase
      line_valid = 1'b1;
      din_valid  = 1'b1;
      din        = v[9:0];
    end
    @(negedge clk);
    line_valid = 1'b0;
    din_valid  = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input int mode, input string nm);
    int k, cyc;
    logic hold, rdy;
    logic [9:0] hr, ht;
    k = 0; cyc = 0; hold = 1'b0; hr = '0; ht = '0;
    while (k < 16 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        chk($sformatf("%s_hold_vld", nm), r_valid, 1);
        chk($sformatf("%s_hold_r", nm), r_data, hr);
        chk($sformatf("%s_hold_t", nm), t_data, ht);
      end
      rdy = (mode == 0) || (((cyc * 5) % 7) < 4);
      out_ready = rdy;
      hold = r_valid && !rdy;
      hr = r_data;
      ht = t_data;
      if (r_valid && rdy) begin
        chk($sformatf("%s_r[%0d]", nm, k), r_data, exp_r[k]);
        chk($sformatf("%s_t[%0d]", nm, k), t_data, exp_t[k]);
        chk($sformatf("%s_tvld[%0d]", nm, k), t_valid, 1);
        chk($sformatf("%s_last[%0d]", nm, k), r_last, (k == 15));
        k++;
      end
    end
    chk($sformatf("%s_count", nm), k, 16);
    out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("%s_done", nm), r_done, 1);
    chk($sformatf("%s_done_t", nm), t_done, 1);
    chk($sformatf("%s_vld_off", nm), r_valid, 0);
    @(negedge clk);
    chk($sformatf("%s_done_pulse", nm), r_done, 0);
    chk($sformatf("%s_idle", nm), r_busy, 0);
  endtask

  initial begin
    int seen_done;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_log2n = '0;
    line_valid = 1'b0; din_valid = 1'b0; din = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", r_valid, 0);
    chk("rst_data", r_data, 0);
    chk("rst_last", r_last, 0);
    chk("rst_busy", r_busy, 0);
    chk("rst_done", r_done, 0);
    chk("rst_err", r_err, 0);
    reset_n = 1'b1;

    // Four lines of i+line: sum 4i+6
    for (int i = 0; i < 16; i++) begin exp_r[i] = i + 2; exp_t[i] = i + 1; end
    do_start(2, "avg4");
    for (int l = 0; l < 4; l++) send_line(16, 0, l);
    drain(0, "avg4");
    chk("avg4_err", r_err, 0);

    // Same data with a stalling consumer
    do_start(2, "stall");
    for (int l = 0; l < 4; l++) send_line(16, 0, l);
    drain(1, "stall");

    // cfg 7 clamps to 6: 64 full-scale lines
    do_start(7, "sat");
    for (int l = 0; l < 63; l++) send_line(16, 1, l);
    chk("clamp_no_out", r_valid, 0);
    chk("clamp_busy", r_busy, 1);
    send_line(16, 1, 63);
    for (int i = 0; i < 16; i++) begin exp_r[i] = 1023; exp_t[i] = 1023; end
    drain(0, "sat");
    chk("sat_err", r_err, 0);

    // Second line short by one: word 15 = (15+17+18) / 4
    do_start(2, "short");
    send_line(16, 0, 0);
    send_line(15, 0, 1);
    send_line(16, 0, 2);
    send_line(16, 0, 3);
    for (int i = 0; i < 16; i++) begin exp_r[i] = i + 2; exp_t[i] = i + 1; end
    exp_r[15] = 13; exp_t[15] = 12;
    drain(0, "short");
    chk("short_err", r_err, 1);
    chk("short_err_t", t_err, 1);

    // Single 17-sample line, pass-through; start clears len_err
    do_start(0, "long");
    send_line(17, 0, 0);
    for (int i = 0; i < 16; i++) begin exp_r[i] = i; exp_t[i] = i; end
    drain(0, "long");
    chk("long_err", r_err, 1);

    // Start while a line is already in progress: that partial line is skipped
    @(negedge clk);
    line_valid = 1'b1; din_valid = 1'b1; din = 10'd500;
    do_start(0, "mid");
    repeat (3) @(negedge clk);
    line_valid = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    send_line(16, 2, 0);
    for (int i = 0; i < 16; i++) begin exp_r[i] = 3 * i; exp_t[i] = 3 * i; end
    drain(0, "mid");
    chk("mid_err", r_err, 0);

    // Abort partway through the second line; len_err from the short first line survives
    do_start(1, "abort");
    send_line(15, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      line_valid = 1'b1; din_valid = 1'b1; din = 10'(i);
    end
    @(negedge clk);
    abort = 1'b1; line_valid = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", r_busy, 0);
    chk("abort_vld", r_valid, 0);
    chk("abort_err_kept", r_err, 1);
    seen_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (r_done) seen_done++;
    end
    chk("abort_no_done", seen_done, 0);

    // Reset while a word is waiting in DRAIN
    do_start(0, "rst");
    out_ready = 1'b0;
    send_line(15, 3, 0);
    for (int i = 0; i < 10 && !r_valid; i++) @(negedge clk);
    chk("rst_wait_vld", r_valid, 1);
    chk("rst_wait_dat", r_data, 5);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", r_valid, 0);
    chk("arst_data", r_data, 0);
    chk("arst_busy", r_busy, 0);
    chk("arst_err", r_err, 0);
    chk("arst_last", r_last, 0);
    chk("arst_done", r_done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/avg_accum_n.md
Name: avg_accum_n

Overview:
- Parametrised coherent averager for the A-scan acquisition path. It sums 2^log2n consecutive lines of LEN samples each into one internal accumulator RAM, using read-modify-write.
- It then streams the scaled average (optionally rounded) to the downstream ARM-side FIFO over a valid/ready handshake.
- Successor to the fixed 32-line, 10-bit, ping-pong-FIFO averager:
  - run-time averaging count;
  - parametrised width and line length;
  - rounding;
  - length-error reporting;
  - abort.

Parameters:
- DW, 10, input sample width (unsigned).
- AW, 13, accumulator RAM address width.
- LEN, 8192, samples per line; LEN <= 2^AW.
- MAX_LOG2N, 6, largest supported log2 of the averaging count.
- ACCW, DW+MAX_LOG2N, accumulator word width; sums can never overflow.
- ROUND, 1, 1 = round half up before shifting; 0 = truncate.

Ports:
- clk, in, 1, clock.
- reset_n, in, 1, asynchronous, active-low reset.
- start, in, 1, single-cycle arm request; sampled only in IDLE.
- abort, in, 1, synchronous abort; returns to IDLE.
- cfg_log2n, in, 3, averaging count = 2^cfg_log2n; latched on start.
- line_valid, in, 1, high for the duration of one acquired line.
- din_valid, in, 1, din is a sample of the current line.
- din, in, DW, sample data.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, downstream accepts (i.e. ~armfifo_full).
- out_data, out, DW, averaged sample.
- out_last, out, 1, high with the final (LEN-1) output word.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse after the last word is accepted.
- len_err, out, 1, sticky; a line delivered more or fewer than LEN samples. Cleared on start.

Behaviour:
- Reset values: out_valid, out_data, out_last, busy, done, len_err = 0. FSM = IDLE, counters = 0. RAM contents are undefined and are never read before being written.
- cfg latching: on start, n_log := min(cfg_log2n, MAX_LOG2N).
- States:
  - IDLE. On start: clear len_err, line_cnt := 0, go to ARM.
  - ARM. If line_valid is already high at entry, wait for it to fall, so averaging never begins mid-line. Go to ACC on the next rising edge of line_valid.
  - ACC. For each din_valid with addr < LEN:
    - read RAM[addr] in cycle t;
    - write RAM[addr] := (line_cnt==0 ? 0 : rd) + din in cycle t+1;
    - addr++.
    - din_valid with addr >= LEN: the sample is discarded and len_err is set.
    - Back-to-back din_valid is supported (1 sample/clk). Addresses strictly increase, so there is no RAW hazard.
    - On the falling edge of line_valid:
      - if addr != LEN, set len_err;
      - addr := 0, line_cnt++;
      - go to DRAIN if line_cnt == 2^n_log - 1 (the last line), else go to ARM.
    - Unwritten positions in a short first line keep stale data; this case is flagged by len_err only.
  - DRAIN. Read addresses 0..LEN-1 through a 1-entry skid so the RAM read latency does not stall.
    - out_data = (acc + (ROUND && n_log>0 ? 2^(n_log-1) : 0)) >> n_log, truncated to DW. The rounding add is done in ACCW+1 bits.
    - The result saturates at 2^DW-1 if the rounded value exceeds that.
    - out_valid stays high and out_data stays stable until out_ready. A word transfers when out_valid && out_ready.
    - out_last marks address LEN-1. After its transfer, go to DONE.
  - DONE. Pulse done for one cycle, then go to IDLE.
- n_log = 0: a single line passes through unchanged (count 1).
- abort in any state: go to IDLE next cycle. out_valid and out_last drop, done is not pulsed, len_err is retained. An in-flight RAM write completing in the abort cycle is allowed.
- start while busy: ignored. line_valid/din_valid outside ARM/ACC: ignored.
- Reset asserted mid-operation: immediate return to reset values. The next run rewrites the RAM on its first line.
- Latency:
  - last sample in to first out_valid: <= 4 clk after the falling edge of line_valid;
  - throughput in DRAIN: 1 word/clk while out_ready is high.

Test Plan:
- LEN=16, cfg_log2n=2, four lines with din[i] = i+line (0..3): out_data[i] = (4i+6+2)>>2 = i+2 for all 16 words; out_last on word 15; done is pulsed; len_err=0.
- Same run, ROUND=0: out_data[i] = (4i+6)>>2 = i+1. With cfg_log2n=7, clamps to 6 and 64 lines are consumed before DRAIN.
- Constant din=1023 for 64 lines (n_log=6): every output is 1023; no overflow or wrap in the accumulator (ACCW=16).
- Toggle out_ready randomly in DRAIN: exactly LEN transfers, in order; out_data is held stable while stalled; no dropped or duplicate words.
- Second line only 15 samples (LEN=16): len_err=1 and the run still completes. A 17-sample line: the extra sample is ignored and len_err=1. The next start clears len_err.
- Start with line_valid already high: the first partial line is skipped. Abort mid-ACC: busy=0 next cycle, no done. Reset mid-DRAIN: all outputs go to 0 immediately.
